// File: rtl/pipe_arith_pkg.sv
// Shared bit-level arithmetic helpers for the pipelined ripple adder/subtractor family.
// Single-bit full subtractor and full adder, each returning {borrow/carry, result}.
package pipe_arith_pkg;

   localparam int PIPE_ARITH_DEF_WIDTH = 4;

   function automatic logic [1:0] full_sub(input logic a, input logic b, input logic bi);
      logic d;
      logic bo;
      d  = a ^ b ^ bi;
      bo = (~a & b) | (~(a ^ b) & bi);
      return {bo, d};
   endfunction

   function automatic logic [1:0] full_add(input logic a, input logic b, input logic ci);
      logic s;
      logic co;
      s  = a ^ b ^ ci;
      co = (a & b) | (ci & (a ^ b));
      return {co, s};
   endfunction

endpackage

// File: rtl/pipe_rbs_if.sv
// Streaming handshake bundle for pipe_rbs: operand side (In_*) and result side (Out_*).
// The Ovf signal exists only when PIPE_RBS_OVF_EN is defined.
interface pipe_rbs_if #(
   parameter int WIDTH = 4
) ();
   logic             In_Valid;
   logic             In_Ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Bin;
   logic             Out_Valid;
   logic             Out_Ready;
   logic [WIDTH-1:0] Diff;
   logic             Bout;
`ifdef PIPE_RBS_OVF_EN
   logic             Ovf;

   modport master (output In_Valid, A, B, Bin, Out_Ready,
                   input  In_Ready, Out_Valid, Diff, Bout, Ovf);
   modport slave  (input  In_Valid, A, B, Bin, Out_Ready,
                   output In_Ready, Out_Valid, Diff, Bout, Ovf);
`else
   modport master (output In_Valid, A, B, Bin, Out_Ready,
                   input  In_Ready, Out_Valid, Diff, Bout);
   modport slave  (input  In_Valid, A, B, Bin, Out_Ready,
                   output In_Ready, Out_Valid, Diff, Bout);
`endif
endinterface

// File: rtl/rbs_stage.sv
// One pipeline stage of pipe_rbs: resolves difference bit IDX and forwards the
// operands, partial difference and borrow to the next stage when adv is high.
module rbs_stage
   import pipe_arith_pkg::*;
#(
   parameter int WIDTH = PIPE_ARITH_DEF_WIDTH,
   parameter int IDX   = 0
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             adv,
   input  logic             valid_in,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic [WIDTH-1:0] diff_in,
   input  logic             borrow_in,
   output logic             valid_out,
   output logic [WIDTH-1:0] a_out,
   output logic [WIDTH-1:0] b_out,
   output logic [WIDTH-1:0] diff_out,
   output logic             borrow_out
);
   logic [1:0]       sub_res;
   logic [WIDTH-1:0] diff_next;
   logic             valid_reg;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] diff_reg;
   logic             borrow_reg;

   // Bit IDX of diff_in is always 0 upstream, so OR-ing places the new bit.
   always_comb begin
      sub_res   = full_sub(a_in[IDX], b_in[IDX], borrow_in);
      diff_next = diff_in | (WIDTH'(sub_res[0]) << IDX);
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         valid_reg  <= 1'b0;
         a_reg      <= '0;
         b_reg      <= '0;
         diff_reg   <= '0;
         borrow_reg <= 1'b0;
      end else if (adv) begin
         valid_reg  <= valid_in;
         a_reg      <= a_in;
         b_reg      <= b_in;
         diff_reg   <= diff_next;
         borrow_reg <= sub_res[1];
      end
   end

   assign valid_out  = valid_reg;
   assign a_out      = a_reg;
   assign b_out      = b_reg;
   assign diff_out   = diff_reg;
   assign borrow_out = borrow_reg;
endmodule

// File: rtl/pipe_rbs.sv
// Pipelined ripple-borrow subtractor Diff = A - B - Bin, one bit per stage, with
// valid/ready back-pressure. Define PIPE_RBS_OVF_EN to add the signed-overflow output Ovf.
module pipe_rbs
   import pipe_arith_pkg::*;
#(
   parameter int WIDTH = PIPE_ARITH_DEF_WIDTH
) (
   input  logic     Clk,
   input  logic     Rst,
   pipe_rbs_if.slave io
);
   logic                        adv;
   logic [WIDTH:0]              valid_s;
   logic [WIDTH:0][WIDTH-1:0]   a_s;
   logic [WIDTH:0][WIDTH-1:0]   b_s;
   logic [WIDTH:0][WIDTH-1:0]   diff_s;
   logic [WIDTH:0]              borrow_s;
   logic                        unused_tail;

   // Whole pipe moves in lockstep; a stalled final stage freezes everything.
   assign adv         = ~valid_s[WIDTH] | io.Out_Ready;
   assign io.In_Ready = adv;

   assign valid_s[0]  = io.In_Valid;
   assign a_s[0]      = io.A;
   assign b_s[0]      = io.B;
   assign diff_s[0]   = '0;
   assign borrow_s[0] = io.Bin;

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_stage
         rbs_stage #(
            .WIDTH (WIDTH),
            .IDX   (gi)
         ) u_stage (
            .Clk        (Clk),
            .Rst        (Rst),
            .adv        (adv),
            .valid_in   (valid_s[gi]),
            .a_in       (a_s[gi]),
            .b_in       (b_s[gi]),
            .diff_in    (diff_s[gi]),
            .borrow_in  (borrow_s[gi]),
            .valid_out  (valid_s[gi+1]),
            .a_out      (a_s[gi+1]),
            .b_out      (b_s[gi+1]),
            .diff_out   (diff_s[gi+1]),
            .borrow_out (borrow_s[gi+1])
         );
      end
   endgenerate

   assign io.Out_Valid = valid_s[WIDTH];
   assign io.Diff      = diff_s[WIDTH];
   assign io.Bout      = borrow_s[WIDTH];

   // Fully consumed operands leave the last stage with no further use.
   assign unused_tail  = ^{a_s[WIDTH], b_s[WIDTH]};

`ifdef PIPE_RBS_OVF_EN
   logic msb_borrow_reg;

   // Borrow into the MSB, captured on the same edge the final stage resolves.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         msb_borrow_reg <= 1'b0;
      end else if (adv) begin
         msb_borrow_reg <= borrow_s[WIDTH-1];
      end
   end

   assign io.Ovf = msb_borrow_reg ^ borrow_s[WIDTH];
`endif
endmodule

// File: tb/tb_pipe_rbs.sv
// Self-checking bench for pipe_rbs (WIDTH=4); Ovf checks active under PIPE_RBS_OVF_EN.
// Expected results come from plain integer subtraction held in a 4-slot latency model.
module tb_pipe_rbs;
   localparam int W = 4;

   logic Clk = 1'b0;
   logic Rst;
   always #5 Clk = ~Clk;

   pipe_rbs_if #(.WIDTH(W)) bus ();

   pipe_rbs #(.WIDTH(W)) dut (
      .Clk (Clk),
      .Rst (Rst),
      .io  (bus.slave)
   );

   int passed;
   int failed;
   int total;
   int xfer_cnt;
   int in_cnt;

   // Model: slot k holds what the DUT's stage k should hold; each entry is {ovf,bout,diff}.
   bit         m_v [4];
   logic [5:0] m_r [4];
   bit         m_zero;

   function automatic logic [5:0] ref_sub(input int a, input int b, input int bin);
      int r;
      int sa;
      int sb;
      int sr;
      logic [3:0] d;
      r  = a - b - bin;
      sa = (a >= 8) ? a - 16 : a;
      sb = (b >= 8) ? b - 16 : b;
      sr = sa - sb - bin;
      d  = 4'(r & 15);
      return {(sr < -8 || sr > 7), (r < 0), d};
   endfunction

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int k = 0; k < 4; k++) begin
         m_v[k] = 1'b0;
         m_r[k] = '0;
      end
   endtask

   task automatic cycle(input bit rst, input bit iv, input logic [3:0] a, input logic [3:0] b,
                        input bit bin, input bit ordy);
      Rst           = rst;
      bus.In_Valid  = iv;
      bus.A         = a;
      bus.B         = b;
      bus.Bin       = bin;
      bus.Out_Ready = ordy;
      @(negedge Clk);
      check("out_valid", 8'(bus.Out_Valid), 8'(m_v[3]));
      check("in_ready", 8'(bus.In_Ready), 8'(!m_v[3] || ordy));
      if (m_zero) begin
         check("rst_diff", 8'(bus.Diff), 8'd0);
         check("rst_bout", 8'(bus.Bout), 8'd0);
`ifdef PIPE_RBS_OVF_EN
         check("rst_ovf", 8'(bus.Ovf), 8'd0);
`endif
      end
      if (m_v[3]) begin
         check("diff", 8'(bus.Diff), 8'(m_r[3][3:0]));
         check("bout", 8'(bus.Bout), 8'(m_r[3][4]));
`ifdef PIPE_RBS_OVF_EN
         check("ovf", 8'(bus.Ovf), 8'(m_r[3][5]));
`endif
      end
      if (!rst && bus.Out_Valid === 1'b1 && ordy) begin
         xfer_cnt++;
         $display("xfer t=%0t diff=%0d bout=%0b", $time, bus.Diff, bus.Bout);
      end
      if (rst) begin
         model_clear();
         m_zero = 1'b1;
      end else if (!m_v[3] || ordy) begin
         if (iv) in_cnt++;
         for (int k = 3; k > 0; k--) begin
            m_v[k] = m_v[k-1];
            m_r[k] = m_r[k-1];
         end
         m_v[0] = iv;
         m_r[0] = ref_sub(int'(a), int'(b), int'(bin));
         m_zero = 1'b0;
      end
      @(posedge Clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      passed   = 0;
      failed   = 0;
      total    = 0;
      xfer_cnt = 0;
      in_cnt   = 0;
      model_clear();
      m_zero   = 1'b0;

      // Reset held three cycles with In_Valid asserted.
      Rst           = 1'b1;
      bus.In_Valid  = 1'b1;
      bus.A         = 4'd7;
      bus.B         = 4'd2;
      bus.Bin       = 1'b0;
      bus.Out_Ready = 1'b1;
      @(posedge Clk);
      #1;
      m_zero = 1'b1;
      cycle(1, 1, 4'd7, 4'd2, 0, 1);
      cycle(1, 1, 4'd7, 4'd2, 0, 1);

      // Basic, underflow and signed-overflow operands.
      cycle(0, 1, 4'd9, 4'd3, 0, 1);
      cycle(0, 1, 4'd0, 4'd1, 0, 1);
      cycle(0, 1, 4'd5, 4'd5, 1, 1);
      cycle(0, 1, 4'd8, 4'd1, 0, 1);
      cycle(0, 1, 4'd3, 4'd2, 0, 1);
      repeat (4) cycle(0, 0, 4'd0, 4'd0, 0, 1);

      // Back-to-back throughput.
      xfer_cnt = 0;
      for (int i = 0; i < 16; i++) cycle(0, 1, 4'(i), 4'(15 - i), 0, 1);
      repeat (4) cycle(0, 0, 4'd0, 4'd0, 0, 1);
      check("thru_count", 8'(xfer_cnt), 8'd16);

      // Random back-pressure.
      xfer_cnt = 0;
      in_cnt   = 0;
      for (int i = 0; i < 300; i++) begin
         cycle(0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      repeat (8) cycle(0, 0, 4'd0, 4'd0, 0, 1);
      check("bp_count", 8'(xfer_cnt), 8'(in_cnt));

      // Mid-flight reset discards three in-flight operands.
      xfer_cnt = 0;
      cycle(0, 1, 4'd12, 4'd4, 0, 1);
      cycle(0, 1, 4'd6, 4'd9, 1, 1);
      cycle(0, 1, 4'd15, 4'd15, 0, 1);
      cycle(1, 0, 4'd0, 4'd0, 0, 1);
      repeat (6) cycle(0, 0, 4'd0, 4'd0, 0, 1);
      check("flush_count", 8'(xfer_cnt), 8'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
